// File: rtl/fen_parse_pkg.sv
// Shared chess encodings for the FEN parser: piece codes, board geometry,
// castle/en-passant bit positions, terminator codes and parser types.
package fen_parse_pkg;

  localparam int PIECE_WIDTH = 4;
  localparam int BOARD_WIDTH = 64 * PIECE_WIDTH;

  // Black codes are the white codes with bit 3 set.
  localparam logic [PIECE_WIDTH-1:0] EMPTY_POSN   = 4'd0;
  localparam logic [PIECE_WIDTH-1:0] WHITE_PAWN   = 4'd1;
  localparam logic [PIECE_WIDTH-1:0] WHITE_KNIGHT = 4'd2;
  localparam logic [PIECE_WIDTH-1:0] WHITE_BISHOP = 4'd3;
  localparam logic [PIECE_WIDTH-1:0] WHITE_ROOK   = 4'd4;
  localparam logic [PIECE_WIDTH-1:0] WHITE_QUEEN  = 4'd5;
  localparam logic [PIECE_WIDTH-1:0] WHITE_KING   = 4'd6;
  localparam logic [PIECE_WIDTH-1:0] BLACK_PAWN   = 4'd9;
  localparam logic [PIECE_WIDTH-1:0] BLACK_KNIGHT = 4'd10;
  localparam logic [PIECE_WIDTH-1:0] BLACK_BISHOP = 4'd11;
  localparam logic [PIECE_WIDTH-1:0] BLACK_ROOK   = 4'd12;
  localparam logic [PIECE_WIDTH-1:0] BLACK_QUEEN  = 4'd13;
  localparam logic [PIECE_WIDTH-1:0] BLACK_KING   = 4'd14;

  localparam int CASTLE_WK_BIT = 0;
  localparam int CASTLE_WQ_BIT = 1;
  localparam int CASTLE_BK_BIT = 2;
  localparam int CASTLE_BQ_BIT = 3;
  localparam int EP_VALID_BIT  = 3;

  localparam logic [7:0] TERM_NUL = 8'h00;
  localparam logic [7:0] TERM_LF  = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PLACE, ST_SIDE, ST_CASTLE, ST_EP, ST_HALF, ST_FULL, ST_DONE, ST_ERROR
  } fen_state_t;

  typedef struct packed {
    logic                   is_piece;
    logic [PIECE_WIDTH-1:0] piece_code;
    logic                   is_digit;
    logic [3:0]             digit_value;
  } char_class_t;

endpackage

// File: rtl/fen_parse_char_decode.sv
// Combinational classifier: piece letters to piece codes, ASCII digits to values.
module fen_char_decode
  import fen_parse_pkg::*;
(
  input  logic [7:0]  char_in,
  output char_class_t cls
);

  always_comb begin
    cls = '0;
    case (char_in)
      "P": begin cls.is_piece = 1'b1; cls.piece_code = WHITE_PAWN;   end
      "N": begin cls.is_piece = 1'b1; cls.piece_code = WHITE_KNIGHT; end
      "B": begin cls.is_piece = 1'b1; cls.piece_code = WHITE_BISHOP; end
      "R": begin cls.is_piece = 1'b1; cls.piece_code = WHITE_ROOK;   end
      "Q": begin cls.is_piece = 1'b1; cls.piece_code = WHITE_QUEEN;  end
      "K": begin cls.is_piece = 1'b1; cls.piece_code = WHITE_KING;   end
      "p": begin cls.is_piece = 1'b1; cls.piece_code = BLACK_PAWN;   end
      "n": begin cls.is_piece = 1'b1; cls.piece_code = BLACK_KNIGHT; end
      "b": begin cls.is_piece = 1'b1; cls.piece_code = BLACK_BISHOP; end
      "r": begin cls.is_piece = 1'b1; cls.piece_code = BLACK_ROOK;   end
      "q": begin cls.is_piece = 1'b1; cls.piece_code = BLACK_QUEEN;  end
      "k": begin cls.is_piece = 1'b1; cls.piece_code = BLACK_KING;   end
      default: ;
    endcase
    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the value.
    if (char_in >= "0" && char_in <= "9") begin
      cls.is_digit    = 1'b1;
      cls.digit_value = char_in[3:0];
    end
  end

endmodule

// File: rtl/fen_parse.sv
// Streaming FEN parser: consumes one ASCII character per cycle and builds the
// board, castle rights, en-passant file, side to move and half-move clock.
module fen_parse
  import fen_parse_pkg::*;
#(
  parameter int HALF_MOVE_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 char_in,
  input  logic                       char_valid,
  output logic                       char_ready,
  output logic [BOARD_WIDTH-1:0]     board,
  output logic [3:0]                 castle_mask,
  output logic [3:0]                 en_passant_col,
  output logic                       white_to_move,
  output logic [HALF_MOVE_WIDTH-1:0] half_move,
  output logic                       done,
  output logic                       error
);

  localparam int HACC_W = HALF_MOVE_WIDTH + 4;
  localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {64{EMPTY_POSN}};

  fen_state_t                 state_reg;
  logic [BOARD_WIDTH-1:0]     board_reg;
  logic [3:0]                 castle_reg;
  logic [3:0]                 ep_reg;
  logic                       wtm_reg;
  logic [HALF_MOVE_WIDTH-1:0] half_reg;
  logic                       done_reg;
  logic                       error_reg;
  logic [2:0]                 row_reg;
  logic [3:0]                 col_reg;
  logic [1:0]                 sub_reg;
  logic [2:0]                 ep_file_reg;

  char_class_t        cls;
  logic               accept;
  logic [4:0]         col_sum;
  logic [5:0]         sq_idx;
  logic [HACC_W-1:0]  half_acc;
  logic               half_ovf;

  fen_char_decode u_decode (
    .char_in (char_in),
    .cls     (cls)
  );

  assign char_ready = (state_reg inside {ST_PLACE, ST_SIDE, ST_CASTLE, ST_EP, ST_HALF, ST_FULL})
                      && !start;
  assign accept     = char_valid && char_ready;
  assign col_sum    = {1'b0, col_reg} + {1'b0, cls.digit_value};
  assign sq_idx     = {row_reg, col_reg[2:0]};
  assign half_acc   = HACC_W'(half_reg) * HACC_W'(10) + HACC_W'(cls.digit_value);
  assign half_ovf   = |half_acc[HACC_W-1:HALF_MOVE_WIDTH];

  // sub_reg tracks progress inside a field: SIDE 0=need letter 1=need space;
  // CASTLE 0=empty 1=letters 2=dash; EP 0=empty 1=need rank 2=need space; HALF 0=empty 1=digits.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      state_reg   <= reset ? ST_IDLE : ST_PLACE;
      board_reg   <= EMPTY_BOARD;
      castle_reg  <= '0;
      ep_reg      <= '0;
      wtm_reg     <= 1'b0;
      half_reg    <= '0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      row_reg     <= 3'd7;
      col_reg     <= 4'd0;
      sub_reg     <= 2'd0;
      ep_file_reg <= 3'd0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == ST_DONE) begin
        state_reg <= ST_IDLE;
      end else if (accept) begin
        case (state_reg)
          ST_PLACE: begin
            if (cls.is_piece) begin
              if (col_reg == 4'd8) begin
                state_reg <= ST_ERROR; error_reg <= 1'b1;
              end else begin
                board_reg[sq_idx*PIECE_WIDTH +: PIECE_WIDTH] <= cls.piece_code;
                col_reg <= col_reg + 4'd1;
              end
            end else if (cls.is_digit) begin
              if (cls.digit_value == 4'd0 || cls.digit_value == 4'd9 || col_sum > 5'd8) begin
                state_reg <= ST_ERROR; error_reg <= 1'b1;
              end else begin
                col_reg <= col_sum[3:0];
              end
            end else if (char_in == "/" && col_reg == 4'd8 && row_reg != 3'd0) begin
              row_reg <= row_reg - 3'd1;
              col_reg <= 4'd0;
            end else if (char_in == " " && col_reg == 4'd8 && row_reg == 3'd0) begin
              state_reg <= ST_SIDE;
              sub_reg   <= 2'd0;
            end else begin
              state_reg <= ST_ERROR; error_reg <= 1'b1;
            end
          end
          ST_SIDE: begin
            if (sub_reg == 2'd0 && (char_in == "w" || char_in == "b")) begin
              wtm_reg <= (char_in == "w");
              sub_reg <= 2'd1;
            end else if (sub_reg == 2'd1 && char_in == " ") begin
              state_reg <= ST_CASTLE;
              sub_reg   <= 2'd0;
            end else begin
              state_reg <= ST_ERROR; error_reg <= 1'b1;
            end
          end
          ST_CASTLE: begin
            if (sub_reg != 2'd2 && char_in == "K") begin
              castle_reg[CASTLE_WK_BIT] <= 1'b1; sub_reg <= 2'd1;
            end else if (sub_reg != 2'd2 && char_in == "Q") begin
              castle_reg[CASTLE_WQ_BIT] <= 1'b1; sub_reg <= 2'd1;
            end else if (sub_reg != 2'd2 && char_in == "k") begin
              castle_reg[CASTLE_BK_BIT] <= 1'b1; sub_reg <= 2'd1;
            end else if (sub_reg != 2'd2 && char_in == "q") begin
              castle_reg[CASTLE_BQ_BIT] <= 1'b1; sub_reg <= 2'd1;
            end else if (sub_reg == 2'd0 && char_in == "-") begin
              sub_reg <= 2'd2;
            end else if (sub_reg != 2'd0 && char_in == " ") begin
              state_reg <= ST_EP;
              sub_reg   <= 2'd0;
            end else begin
              state_reg <= ST_ERROR; error_reg <= 1'b1;
            end
          end
          ST_EP: begin
            if (sub_reg == 2'd0 && char_in == "-") begin
              sub_reg <= 2'd2;
            end else if (sub_reg == 2'd0 && char_in >= "a" && char_in <= "h") begin
              // 'a'..'h' are 0x61..0x68: low three bits minus one give the file.
              ep_file_reg <= char_in[2:0] - 3'd1;
              sub_reg     <= 2'd1;
            end else if (sub_reg == 2'd1 && (char_in == "3" || char_in == "6")) begin
              ep_reg[EP_VALID_BIT] <= 1'b1;
              ep_reg[2:0]          <= ep_file_reg;
              sub_reg              <= 2'd2;
            end else if (sub_reg == 2'd2 && char_in == " ") begin
              state_reg <= ST_HALF;
              sub_reg   <= 2'd0;
            end else begin
              state_reg <= ST_ERROR; error_reg <= 1'b1;
            end
          end
          ST_HALF: begin
            if (cls.is_digit && !half_ovf) begin
              half_reg <= half_acc[HALF_MOVE_WIDTH-1:0];
              sub_reg  <= 2'd1;
            end else if (sub_reg == 2'd1 && char_in == " ") begin
              state_reg <= ST_FULL;
              sub_reg   <= 2'd0;
            end else begin
              state_reg <= ST_ERROR; error_reg <= 1'b1;
            end
          end
          ST_FULL: begin
            if (char_in == TERM_NUL || char_in == TERM_LF) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (!cls.is_digit) begin
              state_reg <= ST_ERROR; error_reg <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign board          = board_reg;
  assign castle_mask    = castle_reg;
  assign en_passant_col = ep_reg;
  assign white_to_move  = wtm_reg;
  assign half_move      = half_reg;
  assign done           = done_reg;
  assign error          = error_reg;

endmodule

// File: tb/tb_fen_parse.sv
// Scoreboard bench for fen_parse: expectations are queued before each FEN
// string is streamed in and popped once the parse has settled.
module tb_fen_parse;
  import fen_parse_pkg::*;

  localparam int HW = 7;
  localparam logic [BOARD_WIDTH-1:0] EMPTY_BOARD = {64{EMPTY_POSN}};
  localparam string START_FEN = "rnbqkbnr/pppppppp/8/8/8/8/PPPPPPPP/RNBQKBNR w KQkq - 0 1";
  localparam string EP_FEN    = "8/8/8/3pP3/8/8/8/8 w - d6 12 40";

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [7:0]             char_in = 8'h00;
  logic                   char_valid = 1'b0;
  logic                   char_ready;
  logic [BOARD_WIDTH-1:0] board;
  logic [3:0]             castle_mask;
  logic [3:0]             en_passant_col;
  logic                   white_to_move;
  logic [HW-1:0]          half_move;
  logic                   done;
  logic                   error;

  always #5 clk = ~clk;

  fen_parse #(.HALF_MOVE_WIDTH(HW)) dut (
    .clk(clk), .reset(reset), .start(start), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .board(board), .castle_mask(castle_mask),
    .en_passant_col(en_passant_col), .white_to_move(white_to_move), .half_move(half_move),
    .done(done), .error(error)
  );

  typedef struct {
    string    name;
    bit       err;
    int       acc;
    int       dones;
    logic [3:0] castle;
    logic [3:0] ep;
    bit       wtm;
    int       half;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int done_cycles = 0;
  int long_done = 0;
  bit prev_done = 1'b0;

  always @(negedge clk) begin
    if (done) done_cycles <= done_cycles + 1;
    if (done && prev_done) long_done <= long_done + 1;
    prev_done <= done;
  end

  function automatic logic [3:0] sq(input int row, input int col);
    return board[(row*8+col)*PIECE_WIDTH +: PIECE_WIDTH];
  endfunction

  function automatic logic [BOARD_WIDTH-1:0] start_board();
    logic [BOARD_WIDTH-1:0] b;
    logic [3:0] wb [8];
    logic [3:0] bb [8];
    wb = '{WHITE_ROOK, WHITE_KNIGHT, WHITE_BISHOP, WHITE_QUEEN, WHITE_KING, WHITE_BISHOP, WHITE_KNIGHT, WHITE_ROOK};
    bb = '{BLACK_ROOK, BLACK_KNIGHT, BLACK_BISHOP, BLACK_QUEEN, BLACK_KING, BLACK_BISHOP, BLACK_KNIGHT, BLACK_ROOK};
    b = EMPTY_BOARD;
    for (int c = 0; c < 8; c++) begin
      b[(0*8+c)*PIECE_WIDTH +: PIECE_WIDTH] = wb[c];
      b[(1*8+c)*PIECE_WIDTH +: PIECE_WIDTH] = WHITE_PAWN;
      b[(6*8+c)*PIECE_WIDTH +: PIECE_WIDTH] = BLACK_PAWN;
      b[(7*8+c)*PIECE_WIDTH +: PIECE_WIDTH] = bb[c];
    end
    return b;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    char_in = "r";
    char_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    char_valid = 1'b0;
  endtask

  // Streams s (plus optional terminator); stops early when the DUT refuses a
  // character or after max_acc accepted characters.
  task automatic send_str(input string s, input bit add_term, input logic [7:0] term,
                          input bit toggle, input int max_acc, output int accepted);
    int n;
    int i;
    int budget;
    n = s.len() + (add_term ? 1 : 0);
    i = 0;
    budget = 0;
    accepted = 0;
    while (i < n && accepted < max_acc && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (toggle && $urandom_range(0, 2) == 0) begin
        char_valid = 1'b0;
      end else begin
        char_in = (i < s.len()) ? s[i] : term;
        char_valid = 1'b1;
        if (char_ready) begin
          accepted++;
          i++;
        end else begin
          char_valid = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", char_ready); end
    checks++; if (board !== EMPTY_BOARD) begin failures++; $display("FAIL reset_board got=%h", board); end
    checks++; if ({castle_mask, en_passant_col, white_to_move, half_move, done, error} !== '0) begin
      failures++; $display("FAIL reset_outputs castle=%h ep=%h wtm=%b half=%0d done=%b err=%b",
                           castle_mask, en_passant_col, white_to_move, half_move, done, error);
    end
  endtask

  task automatic run_and_check(input string s, input bit add_term, input logic [7:0] term,
                               input bit toggle, input logic [BOARD_WIDTH-1:0] exp_board,
                               input bit check_board);
    int acc;
    int d0;
    exp_t e;
    d0 = done_cycles;
    pulse_start();
    send_str(s, add_term, term, toggle, 1000, acc);
    repeat (3) @(negedge clk);
    e = sb.pop_front();
    checks++; if (acc != e.acc) begin failures++; $display("FAIL %s accepted got=%0d exp=%0d", e.name, acc, e.acc); end
    checks++; if (error !== e.err) begin failures++; $display("FAIL %s error got=%b exp=%b", e.name, error, e.err); end
    checks++; if (done_cycles - d0 != e.dones) begin failures++; $display("FAIL %s done_pulses got=%0d exp=%0d", e.name, done_cycles - d0, e.dones); end
    if (!e.err) begin
      checks++; if (castle_mask !== e.castle) begin failures++; $display("FAIL %s castle got=%b exp=%b", e.name, castle_mask, e.castle); end
      checks++; if (en_passant_col !== e.ep) begin failures++; $display("FAIL %s ep got=%b exp=%b", e.name, en_passant_col, e.ep); end
      checks++; if (white_to_move !== e.wtm) begin failures++; $display("FAIL %s wtm got=%b exp=%b", e.name, white_to_move, e.wtm); end
      checks++; if (half_move !== HW'(e.half)) begin failures++; $display("FAIL %s half got=%0d exp=%0d", e.name, half_move, e.half); end
    end else begin
      checks++; if (char_ready !== 1'b0) begin failures++; $display("FAIL %s ready_in_error got=%b exp=0", e.name, char_ready); end
    end
    if (check_board) begin
      checks++; if (board !== exp_board) begin failures++; $display("FAIL %s board got=%h exp=%h", e.name, board, exp_board); end
    end
    $display("txn %s accepted=%0d error=%b done_pulses=%0d", e.name, acc, error, done_cycles - d0);
  endtask

  task automatic test_start_position();
    sb.push_back('{"start_pos", 1'b0, 57, 1, 4'b1111, 4'b0000, 1'b1, 0});
    run_and_check(START_FEN, 1'b1, TERM_NUL, 1'b0, start_board(), 1'b1);
    checks++; if (sq(0, 0) !== WHITE_ROOK || sq(7, 4) !== BLACK_KING) begin
      failures++; $display("FAIL start_squares a1=%0d e8=%0d exp=%0d,%0d", sq(0, 0), sq(7, 4), WHITE_ROOK, BLACK_KING);
    end
    checks++; if (long_done != 0) begin failures++; $display("FAIL done_width long=%0d exp=0", long_done); end
  endtask

  task automatic test_ep_position();
    logic [BOARD_WIDTH-1:0] b;
    b = EMPTY_BOARD;
    b[(4*8+3)*PIECE_WIDTH +: PIECE_WIDTH] = BLACK_PAWN;
    b[(4*8+4)*PIECE_WIDTH +: PIECE_WIDTH] = WHITE_PAWN;
    sb.push_back('{"ep_pos", 1'b0, EP_FEN.len() + 1, 1, 4'b0000, 4'b1011, 1'b1, 12});
    run_and_check(EP_FEN, 1'b1, TERM_LF, 1'b0, b, 1'b1);
  endtask

  task automatic test_errors();
    string s [5];
    int acc [5];
    s   = '{"9/8/8/8/8/8/8/8 w - - 0 1", "7/8/8/8/8/8/8/8 w - - 0 1", "4p4/8/8/8/8/8/8/8 w - - 0 1",
            "8/8/8/8/8/8/8/8 w -K - 0 1", "8/8/8/8/8/8/8/8 w -"};
    acc = '{1, 2, 3, 20, 20};
    for (int k = 0; k < 5; k++) begin
      sb.push_back('{$sformatf("err%0d", k), 1'b1, acc[k], 0, 4'b0, 4'b0, 1'b0, 0});
      run_and_check(s[k], (k == 4), TERM_NUL, 1'b0, EMPTY_BOARD, 1'b0);
    end
  endtask

  task automatic test_valid_toggle();
    sb.push_back('{"toggle", 1'b0, 57, 1, 4'b1111, 4'b0000, 1'b1, 0});
    run_and_check(START_FEN, 1'b1, TERM_NUL, 1'b1, start_board(), 1'b1);
  endtask

  task automatic test_reset_mid();
    int acc;
    int d0;
    d0 = done_cycles;
    pulse_start();
    send_str(START_FEN, 1'b0, TERM_NUL, 1'b0, 20, acc);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (acc != 20) begin failures++; $display("FAIL midreset_accepted got=%0d exp=20", acc); end
    checks++; if (board !== EMPTY_BOARD || char_ready !== 1'b0) begin
      failures++; $display("FAIL midreset_state board=%h ready=%b", board, char_ready);
    end
    checks++; if ({castle_mask, en_passant_col, white_to_move, half_move, error} !== '0 || done_cycles != d0) begin
      failures++; $display("FAIL midreset_outputs castle=%h ep=%h wtm=%b half=%0d err=%b dones=%0d",
                           castle_mask, en_passant_col, white_to_move, half_move, error, done_cycles - d0);
    end
    $display("txn midreset accepted=%0d", acc);
  endtask

  task automatic test_restart_half();
    int acc;
    pulse_start();
    send_str("8/8/8/8/8/8/8/8 w K - 1", 1'b0, TERM_NUL, 1'b0, 1000, acc);
    checks++; if (half_move !== HW'(1) || castle_mask !== 4'b0001) begin
      failures++; $display("FAIL half_partial half=%0d castle=%b exp=1,0001", half_move, castle_mask);
    end
    sb.push_back('{"restart", 1'b0, EP_FEN.len() + 1, 1, 4'b0000, 4'b1011, 1'b1, 12});
    run_and_check(EP_FEN, 1'b1, TERM_LF, 1'b0, EMPTY_BOARD, 1'b0);
    checks++; if (sq(4, 3) !== BLACK_PAWN || sq(4, 4) !== WHITE_PAWN) begin
      failures++; $display("FAIL restart_squares d5=%0d e5=%0d", sq(4, 3), sq(4, 4));
    end
  endtask

  task automatic test_half_limits();
    string pre;
    pre = "8/8/8/8/8/8/8/8 w - - ";
    sb.push_back('{"half128", 1'b1, pre.len() + 3, 0, 4'b0, 4'b0, 1'b0, 0});
    run_and_check({pre, "128 1"}, 1'b1, TERM_LF, 1'b0, EMPTY_BOARD, 1'b0);
    sb.push_back('{"half127", 1'b0, pre.len() + 6, 1, 4'b0, 4'b0, 1'b1, 127});
    run_and_check({pre, "127 1"}, 1'b1, TERM_LF, 1'b0, EMPTY_BOARD, 1'b1);
  endtask

  initial begin
    test_reset();
    test_start_position();
    test_ep_position();
    test_errors();
    test_valid_toggle();
    test_reset_mid();
    test_restart_half();
    test_half_limits();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
